// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// type and the request fault check.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

  // A request faults on an unsupported width code or a misaligned half/word.
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic legal;
    if (we) legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    else    legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                    (funct3 == LBU) || (funct3 == LHU);
    case (funct3[1:0])
      2'b01:   return !legal || addr_lo[0];
      2'b10:   return !legal || (addr_lo != 2'b00);
      default: return !legal;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword lane out of a raw memory word and
// sign- or zero-extends it according to the load width code.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, then extension by width code
  always_comb begin
    byte_v = 8'(rdata >> {addr_lo, 3'b000});
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{24{byte_v[7]}}, byte_v};
      LH:      data = {{16{half_v[15]}}, half_v};
      LW:      data = rdata;
      LBU:     data = {24'h0, byte_v};
      LHU:     data = {16'h0, half_v};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one core request at a time, checks
// alignment, drives a single-outstanding memory handshake and returns a
// one-cycle response carrying aligned/extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            req_fault;
  logic [XLEN-1:0] load_data;

  assign req_fault = access_fault(req_we, req_funct3, req_addr[1:0]);

  load_align u_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (load_data)
  );

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state: faults skip memory entirely, stores skip the read wait
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = req_fault ? RESP : REQ;
      REQ:  if (mem_ready) state_d = we_q ? RESP : WAIT;
      WAIT: if (mem_rvalid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request in IDLE; resp data is zero unless a load completes
  always_comb begin
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        mis_d   = req_fault;
        if (req_fault) rdata_d = '0;
      end
      REQ:  if (mem_ready && we_q) rdata_d = '0;
      WAIT: if (mem_rvalid) rdata_d = load_data;
      default: ;
    endcase
  end

  // Outputs: memory fields only driven while the request is presented
  always_comb begin
    req_ready       = (state_q == IDLE);
    mem_valid       = (state_q == REQ);
    resp_valid      = (state_q == RESP);
    resp_misaligned = (state_q == RESP) && mis_q;
    resp_rdata      = rdata_q;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wstrb       = 4'b0000;
    mem_wdata       = '0;
    if (state_q == REQ) begin
      mem_we   = we_q;
      mem_addr = {addr_q[XLEN-1:2], 2'b00};
      case (f3_q[1:0])
        2'b00: begin
          mem_wstrb = we_q ? 4'(4'b0001 << addr_q[1:0]) : 4'b0000;
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_wstrb = we_q ? 4'(4'b0011 << {addr_q[1], 1'b0}) : 4'b0000;
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_wstrb = we_q ? 4'b1111 : 4'b0000;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level reference
// model and a few literal anchor cases.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned)
  );

  int checks = 0;
  int errors = 0;

  // Model state for the transaction in flight
  bit          chk_en = 0, busy = 0;
  bit          exp_fault, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_strb;
  int          exp_lat, cyc;
  logic [31:0] last_resp = 32'h0;
  bit          rst_prev = 1'b0;

  // Literal anchors for directed cases
  bit          pin_en = 0, pin_mem_en = 0;
  logic [31:0] pin_rdata, pin_maddr, pin_mwdata;
  logic [3:0]  pin_strb;
  bit          pin_mis;
  int          pin_lat;

  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic bit m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    return (a % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int mask;
    if (!we) return 4'b0000;
    mask = (1 << size_bytes(f3)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_bytes(f3))
      1:       return 32'(d & 32'hFF) * 32'h01010101;
      2:       return 32'(d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * int'(a % 4))) & 32'hFF;
    h = (d >> (16 * int'((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd2:    return d;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Compare process: every cycle after reset, outputs vs the model
  always @(negedge clk) begin
    if (rst_prev) last_resp = 32'h0;
    rst_prev = rst;
    if (chk_en && !rst) begin
      chk("req_ready", 32'(req_ready), 32'(!busy));
      if (!resp_valid) begin
        chk("mis_idle", 32'(resp_misaligned), 32'h0);
        chk("rdata_hold", resp_rdata, last_resp);
      end
      if (!busy) begin
        chk("idle_mem_valid", 32'(mem_valid), 32'h0);
        chk("idle_resp_valid", 32'(resp_valid), 32'h0);
      end else begin
        if (mem_valid) begin
          chk("mem_valid_fault", 32'(exp_fault), 32'h0);
          chk("mem_addr", mem_addr, exp_addr);
          chk("mem_we", 32'(mem_we), 32'(exp_we));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
          if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
          if (pin_mem_en) begin
            chk("pin_mem_addr", mem_addr, pin_maddr);
            chk("pin_mem_wstrb", 32'(mem_wstrb), 32'(pin_strb));
            chk("pin_mem_wdata", mem_wdata, pin_mwdata);
          end
        end
        if (resp_valid) begin
          chk("latency", 32'(cyc), 32'(exp_lat));
          chk("resp_mis", 32'(resp_misaligned), 32'(exp_fault));
          chk("resp_rdata", resp_rdata, exp_rdata);
          last_resp = exp_rdata;
          if (pin_en) begin
            chk("pin_latency", 32'(cyc), 32'(pin_lat));
            chk("pin_mis", 32'(resp_misaligned), 32'(pin_mis));
            chk("pin_rdata", resp_rdata, pin_rdata);
          end
        end
      end
    end
  end

  // One transaction: rd = mem_ready delay, vd = rvalid delay after accept,
  // rst_at = cycle after request accept at which to pulse reset (0 = none)
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rdat,
                     input int rd, input int vd, input int rst_at);
    int  acc, c;
    bit  done;
    exp_fault = m_fault(we, f3, a);
    exp_we    = we;
    exp_addr  = {a[31:2], 2'b00};
    exp_strb  = m_strb(we, f3, a);
    exp_wdata = m_wdata(f3, wd);
    exp_rdata = (we || exp_fault) ? 32'h0 : m_load(f3, a, rdat);
    exp_lat   = exp_fault ? 1 : (we ? 2 + rd : 3 + rd + vd);
    acc = 1 + rd;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    busy = 1; c = 1; done = 0;
    while (!done) begin
      cyc = c;
      req_valid  = 1'($urandom % 2);
      req_we     = 1'($urandom % 2);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      mem_ready  = (c >= acc);
      if (!we && !exp_fault && c > acc) begin
        mem_rvalid = (c == acc + 1 + vd);
        mem_rdata  = mem_rvalid ? rdat : $urandom;
      end else begin
        mem_rvalid = 1'($urandom % 2);
        mem_rdata  = $urandom;
      end
      if (rst_at == c) rst = 1'b1;
      @(negedge clk);
      if (resp_valid) done = 1;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0; busy = 0; req_valid = 1'b0;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = rdat;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        return;
      end
      c++;
      if (c > 80) begin
        $display("FAIL timeout waiting for resp_valid actual=none required=cycle %0d", exp_lat);
        $fatal(1, "timeout");
      end
    end
    busy = 0; req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic        we;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1;
    @(posedge clk); #1;

    // LB / LBU lane 3 of 0x80FF1234
    pin_en = 1; pin_mis = 0; pin_lat = 3; pin_rdata = 32'hFFFFFF80;
    run(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 0);
    pin_rdata = 32'h00000080;
    run(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 0);
    // SH to upper halfword
    pin_mem_en = 1; pin_maddr = 32'h200; pin_strb = 4'b1100; pin_mwdata = 32'hBEEFBEEF;
    pin_lat = 2; pin_rdata = 32'h0;
    run(1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 0, 0, 0);
    // misaligned LW faults immediately
    pin_mem_en = 0; pin_mis = 1; pin_lat = 1; pin_rdata = 32'h0;
    run(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 0, 0);
    // SW stalled 5 cycles, spurious req_valid while busy
    pin_mem_en = 1; pin_maddr = 32'h400; pin_strb = 4'b1111; pin_mwdata = 32'hCAFEF00D;
    pin_mis = 0; pin_lat = 7;
    run(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 5, 0, 0);
    pin_en = 0; pin_mem_en = 0;
    // load that leaves a non-zero held value, then reset in WAIT and in REQ
    run(1'b0, 3'b010, 32'h80, 32'h0, 32'hA5A5A5A5, 0, 0, 0);
    run(1'b0, 3'b010, 32'h84, 32'h0, 32'h11112222, 0, 5, 3);
    run(1'b1, 3'b000, 32'h85, 32'h77, 32'h0, 4, 0, 2);

    for (int i = 0; i < 250; i++) begin
      a  = $urandom;
      we = 1'($urandom % 2);
      if ($urandom % 4 != 0) a[1:0] = 2'($urandom % 2) << 1 & 2'(($urandom % 2) ? 2'b11 : 2'b10);
      run(we, 3'($urandom), a, $urandom, $urandom,
          int'($urandom % 4), int'($urandom % 3), 0);
    end

    @(posedge clk); #1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
